// File: rtl/histogram_extent_finder_pkg.sv
// -----------------------------------------------------------------------------
// histogram_extent_finder_pkg
// Shared definitions for the histogram extent finder and its per-axis scanner:
// default bin geometry (common with the median-filter/histogram stage), the
// CLEAR timeout default and the controller state encoding.
// -----------------------------------------------------------------------------
package histogram_extent_finder_pkg;

    localparam int unsigned HIST_NUM_BINS    = 256;
    localparam int unsigned HIST_IDX_W       = 8;
    localparam int unsigned HIST_CNT_W       = 8;
    localparam int unsigned HIST_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        STREAM = 3'd2,
        CLEAR  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/histogram_extent_finder_axis_scan_accum.sv
// -----------------------------------------------------------------------------
// axis_scan_accum
// Scans one axis histogram stream (bins arrive in index order) and tracks the
// peak bin plus the first/last bin whose count reaches the threshold.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   i_clear         zero the accumulator before a new scan
//   i_enable        accept bins only while the controller is streaming
//   i_valid/i_count bin strobe and bin count
//   i_threshold     extent qualification level
//   o_binIndex      bins accepted so far (0..NUM_BINS)
//   o_peakIndex/o_peakCount  max-count bin (lowest index wins ties)
//   o_min/o_max/o_found      extent of qualifying bins
//   o_axisDone      all NUM_BINS bins have been accepted
// -----------------------------------------------------------------------------
module axis_scan_accum
    import histogram_extent_finder_pkg::*;
#(
    parameter int unsigned NUM_BINS = HIST_NUM_BINS,
    parameter int unsigned IDX_W    = HIST_IDX_W,
    parameter int unsigned CNT_W    = HIST_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_count,
    input  logic [CNT_W-1:0] i_threshold,
    output logic [IDX_W:0]   o_binIndex,
    output logic [IDX_W-1:0] o_peakIndex,
    output logic [CNT_W-1:0] o_peakCount,
    output logic [IDX_W-1:0] o_min,
    output logic [IDX_W-1:0] o_max,
    output logic             o_found,
    output logic             o_axisDone
);

    logic [IDX_W:0]   r_binIdx;
    logic [IDX_W-1:0] r_peakIdx;
    logic [CNT_W-1:0] r_peakCnt;
    logic [IDX_W-1:0] r_min;
    logic [IDX_W-1:0] r_max;
    logic             r_found;

    logic             w_done;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx;

    assign w_done   = (r_binIdx == (IDX_W+1)'(NUM_BINS));
    // Bins beyond the last index are dropped so a stray strobe cannot corrupt
    // results while the other axis is still streaming.
    assign w_accept = i_enable && i_valid && !w_done;
    assign w_idx    = r_binIdx[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_binIdx  <= '0;
            r_peakIdx <= '0;
            r_peakCnt <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_found   <= 1'b0;
        end else if (w_accept) begin
            r_binIdx <= r_binIdx + 1'b1;
            if (i_count > r_peakCnt) begin
                r_peakIdx <= w_idx;
                r_peakCnt <= i_count;
            end
            if (i_count >= i_threshold) begin
                if (!r_found) begin
                    r_min <= w_idx;
                end
                r_max   <= w_idx;
                r_found <= 1'b1;
            end
        end
    end

    assign o_binIndex  = r_binIdx;
    assign o_peakIndex = r_peakIdx;
    assign o_peakCount = r_peakCnt;
    assign o_min       = r_min;
    assign o_max       = r_max;
    assign o_found     = r_found;
    assign o_axisDone  = w_done;

endmodule

// File: rtl/histogram_extent_finder.sv
// -----------------------------------------------------------------------------
// histogram_extent_finder
// After a frame completes, requests the X/Y projection histograms, scans both
// streams for peak bin and object extent, clears the histograms and publishes
// the results with a one-cycle resultValid strobe.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   startAnalysis              start pulse (ignored unless idle)
//   binThreshold               extent threshold, latched on start
//   readHistogram              one-cycle histogram stream request
//   clearHistogram             clear request, held until histogramCleared
//   xHistogramIn/xValid        X bin stream;  yHistogramIn/yValid  Y bin stream
//   histogramCleared           clear acknowledge
//   busy                       controller not idle
//   resultValid                one-cycle result strobe
//   x/yPeakIndex, x/yPeakCount peak bin per axis
//   x/yMin, x/yMax, x/yFound   extent per axis
//   timeoutErr                 CLEAR timed out
// Build option: define HIST_EXTENT_TIMEOUT_EN to abort CLEAR after TIMEOUT_CYC
// cycles without acknowledge; otherwise CLEAR waits forever, timeoutErr = 0.
// -----------------------------------------------------------------------------
module histogram_extent_finder
    import histogram_extent_finder_pkg::*;
#(
    parameter int unsigned NUM_BINS    = HIST_NUM_BINS,
    parameter int unsigned IDX_W       = HIST_IDX_W,
    parameter int unsigned CNT_W       = HIST_CNT_W,
    parameter int unsigned TIMEOUT_CYC = HIST_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startAnalysis,
    input  logic [CNT_W-1:0] binThreshold,
    output logic             readHistogram,
    output logic             clearHistogram,
    input  logic [CNT_W-1:0] xHistogramIn,
    input  logic             xValid,
    input  logic [CNT_W-1:0] yHistogramIn,
    input  logic             yValid,
    input  logic             histogramCleared,
    output logic             busy,
    output logic             resultValid,
    output logic [IDX_W-1:0] xPeakIndex,
    output logic [IDX_W-1:0] yPeakIndex,
    output logic [CNT_W-1:0] xPeakCount,
    output logic [CNT_W-1:0] yPeakCount,
    output logic [IDX_W-1:0] xMin,
    output logic [IDX_W-1:0] xMax,
    output logic [IDX_W-1:0] yMin,
    output logic [IDX_W-1:0] yMax,
    output logic             xFound,
    output logic             yFound,
    output logic             timeoutErr
);

    state_t           r_state;
    logic [CNT_W-1:0] r_thr;
    logic             r_readHistogram;
    logic             r_clearHistogram;
    logic             r_resultValid;
    logic [IDX_W-1:0] r_xPeakIndex, r_yPeakIndex, r_xMin, r_xMax, r_yMin, r_yMax;
    logic [CNT_W-1:0] r_xPeakCount, r_yPeakCount;
    logic             r_xFound, r_yFound;

    logic             w_start;
    logic             w_stream;
    logic             w_timeout;
    logic [IDX_W:0]   w_xBinIdx_unused, w_yBinIdx_unused;
    logic [IDX_W-1:0] w_xPeakIdx, w_yPeakIdx, w_xMin, w_xMax, w_yMin, w_yMax;
    logic [CNT_W-1:0] w_xPeakCnt, w_yPeakCnt;
    logic             w_xFound, w_yFound, w_xDone, w_yDone;

    assign w_start  = (r_state == IDLE) && startAnalysis;
    assign w_stream = (r_state == STREAM);

    axis_scan_accum #(.NUM_BINS(NUM_BINS), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_xScan (
        .clk(clk), .reset(reset), .i_clear(w_start), .i_enable(w_stream),
        .i_valid(xValid), .i_count(xHistogramIn), .i_threshold(r_thr),
        .o_binIndex(w_xBinIdx_unused), .o_peakIndex(w_xPeakIdx), .o_peakCount(w_xPeakCnt),
        .o_min(w_xMin), .o_max(w_xMax), .o_found(w_xFound), .o_axisDone(w_xDone)
    );

    axis_scan_accum #(.NUM_BINS(NUM_BINS), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_yScan (
        .clk(clk), .reset(reset), .i_clear(w_start), .i_enable(w_stream),
        .i_valid(yValid), .i_count(yHistogramIn), .i_threshold(r_thr),
        .o_binIndex(w_yBinIdx_unused), .o_peakIndex(w_yPeakIdx), .o_peakCount(w_yPeakCnt),
        .o_min(w_yMin), .o_max(w_yMax), .o_found(w_yFound), .o_axisDone(w_yDone)
    );

`ifdef HIST_EXTENT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_toCnt;
    logic            r_timeoutErr;

    // Counter is 0 on the first CLEAR cycle, so the abort lands on cycle TIMEOUT_CYC.
    assign w_timeout = (r_state == CLEAR) && (r_toCnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_toCnt      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_toCnt <= (r_state == CLEAR) ? r_toCnt + 1'b1 : '0;
            if (w_start) begin
                r_timeoutErr <= 1'b0;
            end else if (w_timeout && !histogramCleared) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    assign timeoutErr = r_timeoutErr;
`else
    logic w_unused_timeoutCyc;
    assign w_unused_timeoutCyc = (TIMEOUT_CYC == 0);
    assign w_timeout           = 1'b0;
    assign timeoutErr          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_thr            <= '0;
            r_readHistogram  <= 1'b0;
            r_clearHistogram <= 1'b0;
            r_resultValid    <= 1'b0;
            r_xPeakIndex     <= '0;
            r_yPeakIndex     <= '0;
            r_xPeakCount     <= '0;
            r_yPeakCount     <= '0;
            r_xMin           <= '0;
            r_xMax           <= '0;
            r_yMin           <= '0;
            r_yMax           <= '0;
            r_xFound         <= 1'b0;
            r_yFound         <= 1'b0;
        end else begin
            r_readHistogram <= 1'b0;
            r_resultValid   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (startAnalysis) begin
                        r_thr           <= binThreshold;
                        r_readHistogram <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: r_state <= STREAM;
                STREAM: begin
                    if (w_xDone && w_yDone) begin
                        r_clearHistogram <= 1'b1;
                        r_state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Results are published together with the strobe so they
                    // are valid during the DONE cycle.
                    if (histogramCleared || w_timeout) begin
                        r_clearHistogram <= 1'b0;
                        r_resultValid    <= 1'b1;
                        r_xPeakIndex     <= w_xPeakIdx;
                        r_yPeakIndex     <= w_yPeakIdx;
                        r_xPeakCount     <= w_xPeakCnt;
                        r_yPeakCount     <= w_yPeakCnt;
                        r_xMin           <= w_xMin;
                        r_xMax           <= w_xMax;
                        r_yMin           <= w_yMin;
                        r_yMax           <= w_yMax;
                        r_xFound         <= w_xFound;
                        r_yFound         <= w_yFound;
                        r_state          <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy           = (r_state != IDLE);
    assign readHistogram  = r_readHistogram;
    assign clearHistogram = r_clearHistogram;
    assign resultValid    = r_resultValid;
    assign xPeakIndex     = r_xPeakIndex;
    assign yPeakIndex     = r_yPeakIndex;
    assign xPeakCount     = r_xPeakCount;
    assign yPeakCount     = r_yPeakCount;
    assign xMin           = r_xMin;
    assign xMax           = r_xMax;
    assign yMin           = r_yMin;
    assign yMax           = r_yMax;
    assign xFound         = r_xFound;
    assign yFound         = r_yFound;

endmodule

// File: tb/tb_histogram_extent_finder.sv
// -----------------------------------------------------------------------------
// tb_histogram_extent_finder
// Drives histogram frames into histogram_extent_finder, pushes the expected
// per-frame result into a scoreboard when the frame is driven and compares it
// when resultValid fires. Define HIST_EXTENT_TIMEOUT_EN for the timeout frame.
// -----------------------------------------------------------------------------
module tb_histogram_extent_finder;

    logic       clk = 1'b0;
    logic       reset, startAnalysis, xValid, yValid, histogramCleared;
    logic [7:0] binThreshold, xHistogramIn, yHistogramIn;
    logic       readHistogram, clearHistogram, busy, resultValid;
    logic [7:0] xPeakIndex, yPeakIndex, xPeakCount, yPeakCount;
    logic [7:0] xMin, xMax, yMin, yMax;
    logic       xFound, yFound, timeoutErr;

    always #5 clk = ~clk;

    histogram_extent_finder #(.NUM_BINS(256), .IDX_W(8), .CNT_W(8), .TIMEOUT_CYC(1024)) dut (
        .clk(clk), .reset(reset), .startAnalysis(startAnalysis), .binThreshold(binThreshold),
        .readHistogram(readHistogram), .clearHistogram(clearHistogram),
        .xHistogramIn(xHistogramIn), .xValid(xValid), .yHistogramIn(yHistogramIn), .yValid(yValid),
        .histogramCleared(histogramCleared), .busy(busy), .resultValid(resultValid),
        .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex), .xPeakCount(xPeakCount), .yPeakCount(yPeakCount),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .xFound(xFound), .yFound(yFound), .timeoutErr(timeoutErr)
    );

    typedef struct packed {
        logic [7:0] xpi, xpc, xmin, xmax;
        logic       xf;
        logic [7:0] ypi, ypc, ymin, ymax;
        logic       yf;
    } res_t;

    res_t        sb[$];
    res_t        mon_e;
    logic [7:0]  xb[256];
    logic [7:0]  yb[256];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned rv_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: peak is first strict maximum, extent is first/last bin >= thr.
    function automatic res_t model(input logic [7:0] thr);
        res_t r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            if (xb[i] > r.xpc) begin r.xpc = xb[i]; r.xpi = 8'(i); end
            if (yb[i] > r.ypc) begin r.ypc = yb[i]; r.ypi = 8'(i); end
        end
        for (int i = 0; i < 256; i++) begin
            if (!r.xf && xb[i] >= thr) begin r.xmin = 8'(i); r.xf = 1'b1; end
            if (!r.yf && yb[i] >= thr) begin r.ymin = 8'(i); r.yf = 1'b1; end
        end
        for (int i = 255; i >= 0; i--) begin
            if (xb[i] >= thr && r.xmax == 0 && r.xf) r.xmax = 8'(i);
            if (yb[i] >= thr && r.ymax == 0 && r.yf) r.ymax = 8'(i);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (resultValid) begin
            rv_count++;
            if (sb.size() == 0) begin
                check_val("unexpected_resultValid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("xPeakIndex", xPeakIndex, mon_e.xpi);
                check_val("xPeakCount", xPeakCount, mon_e.xpc);
                check_val("xMin", xMin, mon_e.xmin);
                check_val("xMax", xMax, mon_e.xmax);
                check_val("xFound", xFound, mon_e.xf);
                check_val("yPeakIndex", yPeakIndex, mon_e.ypi);
                check_val("yPeakCount", yPeakCount, mon_e.ypc);
                check_val("yMin", yMin, mon_e.ymin);
                check_val("yMax", yMax, mon_e.ymax);
                check_val("yFound", yFound, mon_e.yf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bins();
        for (int i = 0; i < 256; i++) begin xb[i] = 8'd0; yb[i] = 8'd0; end
    endtask

    task automatic rand_bins(input int unsigned hi);
        for (int i = 0; i < 256; i++) begin
            xb[i] = 8'($urandom_range(0, hi));
            yb[i] = 8'($urandom_range(0, hi));
        end
    endtask

    task automatic start_frame(input logic [7:0] thr);
        binThreshold  = thr;
        startAnalysis = 1'b1;
        tick();
        startAnalysis = 1'b0;
        binThreshold  = ~thr;  // threshold must already be latched
        check_val("readHistogram_latency", readHistogram, 1);
        check_val("busy_req", busy, 1);
        check_val("timeoutErr_cleared", timeoutErr, 0);
        tick();
        check_val("readHistogram_pulse", readHistogram, 0);
    endtask

    // mode 0: delayed ack, 1: ack raised before CLEAR entry, 2: no ack (timeout)
    task automatic run_frame(input logic [7:0] thr, input bit skew, input int mode);
        int unsigned rv0;
        int unsigned cnt;
        sb.push_back(model(thr));
        rv0 = rv_count;
        start_frame(thr);
        if (!skew) begin
            for (int i = 0; i < 256; i++) begin
                xValid = 1'b1; xHistogramIn = xb[i];
                yValid = 1'b1; yHistogramIn = yb[i];
                if (i == 255 && mode == 1) histogramCleared = 1'b1;
                tick();
            end
        end else begin
            for (int i = 0; i < 256; i++) begin
                xValid = 1'b1; xHistogramIn = xb[i];
                tick();
            end
            xValid = 1'b0;
            for (int i = 0; i < 300; i++) begin
                xValid        = (i == 10);
                xHistogramIn  = 8'hFF;
                startAnalysis = (i == 150);
                tick();
                if (i == 150) check_val("mid_start_ignored", readHistogram, 0);
            end
            xValid = 1'b0;
            startAnalysis = 1'b0;
            for (int i = 0; i < 256; i++) begin
                yValid = 1'b1; yHistogramIn = yb[i];
                if (i == 255 && mode == 1) histogramCleared = 1'b1;
                tick();
            end
        end
        check_val("clear_not_early", clearHistogram, 0);
        // Late strobes after the last bin must be ignored.
        xValid = 1'b1; xHistogramIn = 8'hFF;
        yValid = 1'b1; yHistogramIn = 8'hFF;
        tick();
        xValid = 1'b0; yValid = 1'b0;
        check_val("clear_rise", clearHistogram, 1);
        if (mode == 2) begin
            cnt = 0;
            while (clearHistogram && cnt < 2000) begin
                cnt++;
                tick();
            end
            check_val("timeout_cycles", cnt, 1024);
        end else begin
            if (mode == 0) begin
                repeat (3) begin
                    tick();
                    check_val("clear_hold", clearHistogram, 1);
                end
                histogramCleared = 1'b1;
            end
            tick();
            histogramCleared = 1'b0;
        end
        check_val("clear_drop", clearHistogram, 0);
        check_val("resultValid_strobe", resultValid, 1);
        check_val("timeoutErr", timeoutErr, (mode == 2));
        tick();
        check_val("resultValid_one_cycle", resultValid, 0);
        check_val("busy_idle", busy, 0);
        check_val("resultValid_count", rv_count, rv0 + 1);
    endtask

    task automatic reset_mid_stream();
        int unsigned rv0;
        rv0 = rv_count;
        start_frame(8'd5);
        for (int i = 0; i < 100; i++) begin
            xValid = 1'b1; xHistogramIn = xb[i];
            yValid = 1'b1; yHistogramIn = yb[i];
            tick();
        end
        xHistogramIn = xb[100]; yHistogramIn = yb[100];
        reset = 1'b1;
        tick();
        check_val("rst_mid_ctrl",
                  {readHistogram, clearHistogram, resultValid, busy, timeoutErr, xFound, yFound}, 0);
        check_val("rst_mid_x", {xPeakIndex, xPeakCount, xMin, xMax}, 0);
        check_val("rst_mid_y", {yPeakIndex, yPeakCount, yMin, yMax}, 0);
        reset = 1'b0;
        xValid = 1'b0; yValid = 1'b0;
        repeat (3) tick();
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_no_result", rv_count, rv0);
    endtask

    initial begin
        reset = 1'b1; startAnalysis = 1'b0; binThreshold = '0;
        xValid = 1'b0; yValid = 1'b0; xHistogramIn = '0; yHistogramIn = '0;
        histogramCleared = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_val("rst_ctrl",
                  {readHistogram, clearHistogram, resultValid, busy, timeoutErr, xFound, yFound}, 0);
        check_val("rst_x", {xPeakIndex, xPeakCount, xMin, xMax}, 0);
        check_val("rst_y", {yPeakIndex, yPeakCount, yMin, yMax}, 0);

        clear_bins(); xb[40] = 8'd5; xb[90] = 8'd7; yb[10] = 8'd3;
        run_frame(8'd3, 1'b0, 0);

        clear_bins(); xb[20] = 8'd9; xb[200] = 8'd9;
        for (int i = 0; i < 256; i++) yb[i] = 8'($urandom_range(0, 15));
        run_frame(8'd9, 1'b0, 1);

        clear_bins();
        run_frame(8'd1, 1'b0, 0);
        run_frame(8'd0, 1'b0, 1);

        rand_bins(200);
        run_frame(8'd100, 1'b1, 0);

        rand_bins(60);
        reset_mid_stream();
        rand_bins(80);
        run_frame(8'd50, 1'b0, 0);

`ifdef HIST_EXTENT_TIMEOUT_EN
        rand_bins(30);
        run_frame(8'd20, 1'b0, 2);
        rand_bins(30);
        run_frame(8'd20, 1'b0, 0);
`endif

        repeat (3) tick();
        check_val("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_extent_finder.md
Name: histogram_extent_finder

Overview:
- Downstream consumer of the median-filter/histogram stage.
- After a filtered frame completes, requests the X and Y projection histograms and scans each 256-bin stream.
- Per axis, reports the peak bin (index and count) and the object extent: first and last bin whose count ≥ binThreshold.
- Then clears the histograms and hands a one-cycle result strobe to the tracking/output logic.

Parameters:
- NUM_BINS, 256, bins per axis histogram (power of two, ≥ 2).
- IDX_W, 8, bin index width (log2 NUM_BINS).
- CNT_W, 8, bin count width, matching the histogram output width.
- TIMEOUT_CYC, 1024, cycles to wait in CLEAR before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startAnalysis  in  1  one-cycle pulse; normally driven by fullImageDone
- binThreshold  in  CNT_W  extent qualification level; sampled in IDLE on start
- readHistogram  out  1  one-cycle request for the histogram stream
- clearHistogram  out  1  clear request, held until acknowledged
- xHistogramIn  in  CNT_W  X bin count
- xValid  in  1  X bin strobe; bins arrive in index order 0..NUM_BINS-1
- yHistogramIn  in  CNT_W  Y bin count
- yValid  in  1  Y bin strobe; independent of xValid
- histogramCleared  in  1  clear acknowledge
- busy  out  1  high in every state except IDLE
- resultValid  out  1  one-cycle result strobe
- xPeakIndex, yPeakIndex  out  IDX_W  index of the max-count bin
- xPeakCount, yPeakCount  out  CNT_W  count of that bin
- xMin, xMax, yMin, yMax  out  IDX_W  first/last qualifying bin
- xFound, yFound  out  1  at least one bin qualified on that axis
- timeoutErr  out  1  CLEAR timed out (optional feature only; tie to 0 otherwise)

Behaviour:
- Reset value of every output is 0. Reset mid-operation aborts immediately to IDLE with no resultValid; result registers clear to 0.
- FSM states: IDLE, REQ, STREAM, CLEAR, DONE.
- IDLE:
  - On startAnalysis: latch binThreshold, clear scan accumulators, go to REQ.
  - startAnalysis in any other state is ignored (no queueing).
- REQ: readHistogram = 1 for exactly this cycle, then STREAM.
- STREAM: each axis has its own IDX_W+1-bit bin counter and accumulator. On a valid for that axis with count c at index i (i = counter value):
  - Peak update: if c > current peak count, peak ← (i, c). Strict compare, so the lowest index wins a tie. All-zero histogram gives peak (0, 0).
  - Extent update: if c ≥ threshold and found = 0, then min ← i, max ← i, found ← 1. If c ≥ threshold and found = 1, then max ← i.
  - Counter increments. Valids arriving after the counter reaches NUM_BINS are ignored.
  - Leave STREAM the cycle after both counters equal NUM_BINS; go to CLEAR.
  - Both valids in the same cycle are handled in parallel.
  - Threshold 0: every bin qualifies, so min = 0 and max = NUM_BINS-1.
- CLEAR:
  - clearHistogram held high while in CLEAR.
  - On histogramCleared = 1: drop clearHistogram next cycle and go to DONE.
  - An acknowledge already high on CLEAR entry is accepted on that first cycle.
- DONE:
  - Results copied to output registers; resultValid = 1 for one cycle; go to IDLE.
  - Outputs hold until the next DONE or reset.
  - No-qualifying-bin axis: found = 0, min = max = 0.
- Latency: start → readHistogram is 1 cycle; last bin → clearHistogram is 1 cycle.

Optional Feature:
- Macro: HIST_EXTENT_TIMEOUT_EN.
- Defined:
  - A counter runs in CLEAR. If TIMEOUT_CYC cycles pass without histogramCleared, drop clearHistogram and go to DONE.
  - Results are still published; timeoutErr is set and stays high until the next startAnalysis or reset.
- Undefined: CLEAR waits indefinitely; timeoutErr is constant 0.

Decomposition:
- Shared package:
  - FSM state encoding localparams (IDLE=0, REQ=1, STREAM=2, CLEAR=3, DONE=4).
  - NUM_BINS/IDX_W/CNT_W defaults shared with the histogram stage.
- One natural sub-module, axis_scan_accum, instantiated twice (X, Y):
  - Inputs: clear, valid, count, threshold.
  - Outputs: binIndex counter, peak index/count, min, max, found, axisDone.

Test Plan:
- X bins all 0 except bin 40 = 5 and bin 90 = 7; Y bin 10 = 3; threshold 3 → xPeak (90, 7), xMin 40, xMax 90, xFound 1; yPeak (10, 3), yMin = yMax = 10; single resultValid.
- Tie: X bins 20 and 200 both = 9, threshold 9 → xPeakIndex 20, xMin 20, xMax 200.
- Empty: all bins 0, threshold 1 → xFound = yFound = 0, min/max/peak all 0. Threshold 0 instead → min 0, max 255.
- Skewed streams: Y stream starts 300 cycles after X ends → clearHistogram rises exactly 1 cycle after the 256th yValid; startAnalysis pulsed mid-stream is ignored.
- Reset asserted during STREAM at bin 100 → all outputs 0 next cycle, busy 0, no resultValid. A new start then gives a correct full scan.
- HIST_EXTENT_TIMEOUT_EN defined, histogramCleared held 0 → clearHistogram drops after 1024 CLEAR cycles, resultValid pulses, timeoutErr = 1.
